// File: rtl/dmem_loader.sv
// Sequencer that bulk-loads a byte stream into data memory or dumps it back out.
// In IDLE (or while reset is high) the CPU owns the memory ports combinationally.
module dmem_loader #(
    localparam int unsigned AW = 4,
    localparam int unsigned DW = 8,
    parameter logic [AW-1:0] LAST_ADDR = 4'd15
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_load_start,
    input  logic          i_dump_start,
    input  logic          i_in_valid,
    input  logic [DW-1:0] i_in_data,
    output logic          o_in_ready_c,
    output logic          o_out_valid_c,
    output logic [DW-1:0] o_out_data_c,
    output logic [AW-1:0] o_out_addr_c,
    input  logic          i_out_ready,
    input  logic          i_cpu_c17,
    input  logic [AW-1:0] i_cpu_write_select,
    input  logic [DW-1:0] i_cpu_inp,
    input  logic [AW-1:0] i_cpu_read_select,
    output logic          o_c17_c,
    output logic [AW-1:0] o_write_select_c,
    output logic [DW-1:0] o_inp_c,
    output logic [AW-1:0] o_read_select_c,
    input  logic [DW-1:0] i_data_memory_output,
    output logic          o_busy_c,
    output logic          o_done
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LOAD     = 2'd1,
        S_DUMP_REQ = 2'd2,
        S_DUMP_OUT = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_cur_state;
    state_t        w_next_state;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] w_next_addr;
    logic          r_done;
    logic          w_next_done;
    logic          w_at_last;

    // State, address counter and completion pulse
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_addr  <= w_next_addr;
            r_done  <= w_next_done;
        end
    end

    // Reset forces IDLE behaviour on the outputs in the same cycle it is seen
    assign w_cur_state = i_reset ? S_IDLE : r_state;
    assign w_at_last   = (r_addr == LAST_ADDR);

    always_comb begin
        w_next_state     = w_cur_state;
        w_next_addr      = r_addr;
        w_next_done      = 1'b0;
        o_c17_c          = 1'b0;
        o_write_select_c = r_addr;
        o_inp_c          = i_in_data;
        o_read_select_c  = r_addr;
        o_in_ready_c     = 1'b0;
        o_out_valid_c    = 1'b0;
        o_busy_c         = 1'b1;

        case (w_cur_state)
            S_IDLE: begin
                o_c17_c          = i_cpu_c17;
                o_write_select_c = i_cpu_write_select;
                o_inp_c          = i_cpu_inp;
                o_read_select_c  = i_cpu_read_select;
                o_busy_c         = 1'b0;
                w_next_addr      = '0;
                if (i_load_start) begin
                    w_next_state = S_LOAD;
                end else if (i_dump_start) begin
                    w_next_state = S_DUMP_REQ;
                end
            end
            S_LOAD: begin
                o_in_ready_c = 1'b1;
                o_c17_c      = i_in_valid;
                if (i_in_valid) begin
                    if (w_at_last) begin
                        w_next_state = S_IDLE;
                        w_next_addr  = '0;
                        w_next_done  = 1'b1;
                    end else begin
                        w_next_addr = AW'(r_addr + AW'(1));
                    end
                end
            end
            S_DUMP_REQ: begin
                w_next_state = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                o_out_valid_c = 1'b1;
                if (i_out_ready) begin
                    if (w_at_last) begin
                        w_next_state = S_IDLE;
                        w_next_addr  = '0;
                        w_next_done  = 1'b1;
                    end else begin
                        w_next_state = S_DUMP_REQ;
                        w_next_addr  = AW'(r_addr + AW'(1));
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_addr  = '0;
            end
        endcase
    end

    assign o_out_data_c = i_data_memory_output;
    assign o_out_addr_c = r_addr;
    assign o_done       = r_done;

endmodule

// File: tb/tb_dmem_loader.sv
// Scoreboard bench for dmem_loader: a shadow memory predicts every write and every dumped word.
module tb_dmem_loader;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;
    localparam int LAST = 15;

    logic          clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_load_start = 1'b0, i_dump_start = 1'b0;
    logic          i_in_valid = 1'b0;
    logic [DW-1:0] i_in_data = '0;
    logic          o_in_ready_c, o_out_valid_c;
    logic [DW-1:0] o_out_data_c;
    logic [AW-1:0] o_out_addr_c;
    logic          i_out_ready = 1'b0;
    logic          i_cpu_c17 = 1'b0;
    logic [AW-1:0] i_cpu_write_select = '0, i_cpu_read_select = '0;
    logic [DW-1:0] i_cpu_inp = '0;
    logic          o_c17_c;
    logic [AW-1:0] o_write_select_c, o_read_select_c;
    logic [DW-1:0] o_inp_c;
    logic [DW-1:0] dmo;
    logic          o_busy_c, o_done;

    dmem_loader #(.LAST_ADDR(4'd15)) dut (
        .i_clock(clk), .i_reset(i_reset),
        .i_load_start(i_load_start), .i_dump_start(i_dump_start),
        .i_in_valid(i_in_valid), .i_in_data(i_in_data), .o_in_ready_c(o_in_ready_c),
        .o_out_valid_c(o_out_valid_c), .o_out_data_c(o_out_data_c),
        .o_out_addr_c(o_out_addr_c), .i_out_ready(i_out_ready),
        .i_cpu_c17(i_cpu_c17), .i_cpu_write_select(i_cpu_write_select),
        .i_cpu_inp(i_cpu_inp), .i_cpu_read_select(i_cpu_read_select),
        .o_c17_c(o_c17_c), .o_write_select_c(o_write_select_c),
        .o_inp_c(o_inp_c), .o_read_select_c(o_read_select_c),
        .i_data_memory_output(dmo), .o_busy_c(o_busy_c), .o_done(o_done)
    );

    always #5 clk = ~clk;

    // Data memory: registered read, synchronous write
    logic [DW-1:0] mem [16];
    initial for (int i = 0; i < 16; i++) mem[i] = '0;
    always @(posedge clk) begin
        dmo <= mem[o_read_select_c];
        if (o_c17_c) mem[o_write_select_c] <= o_inp_c;
    end

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] ref_mem [16];
    logic [11:0] exp_wr [$];
    logic [11:0] exp_rd [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Write monitor: every memory write must be one the model predicted
    always @(negedge clk) begin
        if (o_c17_c === 1'b1) begin
            if (exp_wr.size() == 0) begin
                chk("unexpected_write", {o_write_select_c, o_inp_c}, 12'hFFF);
            end else begin
                logic [11:0] e;
                e = exp_wr.pop_front();
                chk("write_addr", 32'(o_write_select_c), 32'(e[11:8]));
                chk("write_data", 32'(o_inp_c), 32'(e[7:0]));
            end
        end
    end

    // Dump monitor: handshake compare, hold-while-stalled, read_select tracking
    logic          hold_pend = 1'b0;
    logic [AW-1:0] hold_addr;
    logic [DW-1:0] hold_data;
    always @(negedge clk) begin
        if (hold_pend) begin
            chk("hold_valid", 32'(o_out_valid_c), 32'd1);
            chk("hold_addr", 32'(o_out_addr_c), 32'(hold_addr));
            chk("hold_data", 32'(o_out_data_c), 32'(hold_data));
        end
        hold_pend = o_out_valid_c && !i_out_ready;
        hold_addr = o_out_addr_c;
        hold_data = o_out_data_c;
        if (o_out_valid_c === 1'b1) begin
            chk("dump_rdsel", 32'(o_read_select_c), 32'(o_out_addr_c));
            if (i_out_ready) begin
                if (exp_rd.size() == 0) begin
                    chk("unexpected_word", {o_out_addr_c, o_out_data_c}, 12'hFFF);
                end else begin
                    logic [11:0] e;
                    e = exp_rd.pop_front();
                    chk("dump_addr", 32'(o_out_addr_c), 32'(e[11:8]));
                    chk("dump_data", 32'(o_out_data_c), 32'(e[7:0]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: continuous, 1: every 3rd cycle, 2: random; abort_at>=0 resets after that many bytes
    task automatic do_load(input int mode, input logic both, input int abort_at);
        int k, cyc;
        logic v;
        logic [DW-1:0] d;
        i_load_start = 1'b1;
        i_dump_start = both;
        tick();
        i_load_start = 1'b0;
        i_dump_start = 1'b0;
        chk("load_busy", 32'(o_busy_c), 32'd1);
        chk("load_in_ready", 32'(o_in_ready_c), 32'd1);
        k = 0;
        cyc = 0;
        while (k <= LAST && cyc < 200) begin
            if (abort_at >= 0 && k == abort_at) break;
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 2) : 1'($urandom_range(0, 1));
            d = (mode == 2 || abort_at >= 0) ? 8'($urandom) : 8'(8'h10 + k);
            i_in_valid = v;
            i_in_data = d;
            i_dump_start = 1'($urandom_range(0, 1));
            if (v) exp_wr.push_back({4'(k), d});
            tick();
            if (v) begin
                ref_mem[k] = d;
                k++;
            end
            cyc++;
        end
        i_in_valid = 1'b0;
        i_dump_start = 1'b0;
        if (abort_at >= 0) begin
            i_reset = 1'b1;
            i_in_valid = 1'b1;
            i_cpu_write_select = 4'($urandom);
            i_cpu_read_select = 4'($urandom);
            #1;
            chk("abort_c17", 32'(o_c17_c), 32'd0);
            chk("abort_wsel_pass", 32'(o_write_select_c), 32'(i_cpu_write_select));
            chk("abort_rsel_pass", 32'(o_read_select_c), 32'(i_cpu_read_select));
            chk("abort_in_ready", 32'(o_in_ready_c), 32'd0);
            tick();
            i_reset = 1'b0;
            i_in_valid = 1'b0;
            chk("abort_done", 32'(o_done), 32'd0);
            chk("abort_busy", 32'(o_busy_c), 32'd0);
            tick();
            chk("abort_done_late", 32'(o_done), 32'd0);
            chk("abort_idle", 32'(o_in_ready_c), 32'd0);
        end else begin
            chk("load_count", 32'(k), 32'(LAST + 1));
            if (mode == 0) chk("load_cycles", 32'(cyc), 32'(LAST + 1));
            chk("load_done", 32'(o_done), 32'd1);
            chk("load_idle_busy", 32'(o_busy_c), 32'd0);
            tick();
            chk("load_done_pulse", 32'(o_done), 32'd0);
        end
        chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    endtask

    // mode 0: always ready, 1: five-cycle stall at address 3, 2: random ready
    task automatic do_dump(input int mode);
        int cyc, stall;
        logic got_done, r;
        i_dump_start = 1'b1;
        i_out_ready = 1'b0;
        tick();
        i_dump_start = 1'b0;
        for (int a = 0; a <= LAST; a++) exp_rd.push_back({4'(a), ref_mem[a]});
        chk("dump_busy", 32'(o_busy_c), 32'd1);
        chk("dump_req_novalid", 32'(o_out_valid_c), 32'd0);
        cyc = 0;
        stall = 0;
        got_done = 1'b0;
        while (!got_done && cyc < 300) begin
            if (mode == 0) r = 1'b1;
            else if (mode == 1) begin
                r = 1'b1;
                if (o_out_valid_c && o_out_addr_c == 4'd3 && stall < 5) begin
                    r = 1'b0;
                    stall++;
                end
            end else r = 1'($urandom_range(0, 1));
            i_out_ready = r;
            tick();
            cyc++;
            if (o_done) got_done = 1'b1;
        end
        i_out_ready = 1'b0;
        chk("dump_done_seen", 32'(got_done), 32'd1);
        if (mode == 0) chk("dump_cycles", 32'(cyc), 32'(2 * (LAST + 1)));
        if (mode == 1) chk("dump_stall_len", 32'(stall), 32'd5);
        chk("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
        tick();
        chk("dump_done_pulse", 32'(o_done), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        tick();
        tick();
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_busy", 32'(o_busy_c), 32'd0);
        chk("rst_in_ready", 32'(o_in_ready_c), 32'd0);
        chk("rst_out_valid", 32'(o_out_valid_c), 32'd0);
        i_reset = 1'b0;
        tick();

        do_load(0, 1'b0, -1);
        do_dump(0);
        do_load(1, 1'b0, -1);
        do_dump(1);
        do_load(2, 1'b1, -1);
        do_dump(2);
        do_load(2, 1'b0, 7);
        do_dump(2);

        // CPU passthrough write in IDLE
        i_cpu_c17 = 1'b1;
        i_cpu_write_select = 4'd9;
        i_cpu_inp = 8'hA5;
        exp_wr.push_back({4'd9, 8'hA5});
        #1;
        chk("idle_c17_pass", 32'(o_c17_c), 32'd1);
        chk("idle_inp_pass", 32'(o_inp_c), 32'hA5);
        tick();
        ref_mem[9] = 8'hA5;
        i_cpu_c17 = 1'b0;
        chk("cpu_wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        do_dump(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
